i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- I2S master transmitter: the playback-side counterpart of the team's I2S receiver.
- Accepts one stereo sample (left + right) through a valid/ready handshake.
- Generates bit clock, word select and serial data from the single fabric clock, in Philips I2S format.
- Sits between the audio processing pipeline (or its output FIFO) and the external DAC pins.

Parameters:
- WIDTH, 16: sample width per channel, in bits.
- SLOT, 16: bit clocks per channel slot. SLOT >= WIDTH; bits after the LSB are zero padding.
- BCLK_DIV, 4: sclk_i cycles per bclk_o period. Even, >= 2.

Ports:
- sclk_i, in, 1: clock. All logic on its rising edge.
- rst_i, in, 1: synchronous reset, active-low.
- leftChan_i, in, WIDTH: left sample, two's complement.
- rightChan_i, in, WIDTH: right sample.
- pktValid_i, in, 1: sample pair valid.
- pktReady_o, out, 1: pending buffer empty; a sample can be accepted.
- bclk_o, out, 1: I2S bit clock.
- ws_o, out, 1: word select; 0 = left, 1 = right.
- sdata_o, out, 1: serial data, MSB first.
- underrun_o, out, 1: one-cycle pulse when a frame starts with no sample pending.

Behaviour:
- Reset (rst_i=0 at a rising edge): all state cleared, pending sample dropped. Outputs: bclk_o=0, ws_o=1, sdata_o=0, pktReady_o=1, underrun_o=0. Internal: divCnt=0, bitCnt=0, active frame=0.
- Divider: divCnt increments every cycle and wraps BCLK_DIV-1 -> 0.
  - bclk_o is registered; it is 1 while divCnt is in [BCLK_DIV/2, BCLK_DIV-1] and 0 otherwise.
  - fallTick = (divCnt == BCLK_DIV-1). On that edge bclk_o goes 0 and ws_o and sdata_o update.
  - ws_o and sdata_o change only on fallTick.
  - First fallTick occurs BCLK_DIV cycles after reset release.
- Bit counter: bitCnt (0..2*SLOT-1) is the value consumed at each fallTick and advances after use, wrapping 2*SLOT-1 -> 0.
- Frame word F, 2*SLOT bits, index 0 first:
  - Indices 0..WIDTH-1 = left MSB..LSB; then zeros up to index SLOT-1.
  - Indices SLOT..SLOT+WIDTH-1 = right MSB..LSB; then zeros.
- At fallTick with bitCnt = p:
  - ws_o <= (p >= SLOT).
  - sdata_o <= F[p-1] for p >= 1.
  - At p=0, sdata_o <= previous frame's F[2*SLOT-1] (the one-bit I2S delay). For the first frame after reset this value is 0.
- Frame load, at fallTick with p=0:
  - If pendValid: F <= pending sample, pendValid <= 0.
  - Otherwise: F <= 0 (mute) and underrun_o pulses high for that one cycle.
- Handshake:
  - pktReady_o = !pendValid.
  - Accept when pktValid_i && pktReady_o: latch both channels, pendValid <= 1.
- Simultaneous accept and frame load: the load uses pending state from before the edge, so the newly accepted sample waits for the next frame.
- When pendValid=1, ready is 0, so no accept collides with a load. pktReady_o returns to 1 the cycle after a load.
- Input data is sampled only at acceptance. Later changes on leftChan_i/rightChan_i have no effect on the frame in flight.
- Throughput: one sample per 2*SLOT*BCLK_DIV cycles. Upstream sees at most one sample of buffering beyond the active frame.

Test Plan (WIDTH=16, SLOT=16, BCLK_DIV=4 unless stated):
1. Reset: hold rst_i=0 for 3 cycles, pktValid_i=0 -> bclk_o=0, ws_o=1, sdata_o=0, pktReady_o=1, underrun_o=0. After release, first bclk_o rise at cycle 2 and fall at cycle 4.
2. Single sample L=16'hA5F0, R=16'h0F0F presented at cycle 0:
   - Accepted at cycle 0; pktReady_o low until the first frame load, high the next cycle.
   - ws_o falls at the first fallTick.
   - sdata_o over fallTicks p=1..16 reads 1010_0101_1111_0000.
   - ws_o rises at p=16; p=17..32 (32 = p0 of the next frame) reads 0000_1111_0000_1111.
3. Backpressure: pktValid_i held high with sample A, then B -> A accepted immediately. B is stalled (pktReady_o=0) until frame 1 loads A, then accepted. B is transmitted in frame 2 with no gap and no underrun_o.
4. Underrun: no samples after reset -> ws_o toggles every 16 bclk_o periods, sdata_o stays 0, and underrun_o pulses exactly one cycle at every p=0 fallTick.
5. Padding (SLOT=24): L=16'hFFFF, R=16'h8001 -> left slot is p=1..16 all ones, p=17..24 zeros. Right slot is p=25 = 1, p=26..39 = 0, p=40 = 1, then zeros until p=48 (= p0 of the next frame).
6. Reset mid-frame: assert rst_i at p=7 of a frame with a sample pending -> outputs return to reset values on the next edge and the pending sample is discarded. After release, the first frame is muted with an underrun_o pulse.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S master transmitter (Philips format).
// Takes one stereo sample pair per frame through a valid/ready handshake and
// serialises it MSB first, with the standard one-bit delay after ws_o changes.
// bclk_o and ws_o are generated from sclk_i by an integer divider.
// One sample is buffered ahead of the frame currently being transmitted.
// Handshake: a pair transfers on any rising sclk_i edge where pktValid_i and
// pktReady_o are both high. pktReady_o is high exactly when the pending buffer
// is empty. pktValid_i and the channel inputs may change freely otherwise.
module i2s_tx #(
  parameter int WIDTH    = 16,
  parameter int SLOT     = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic             sclk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] leftChan_i,
  input  logic [WIDTH-1:0] rightChan_i,
  input  logic             pktValid_i,
  output logic             pktReady_o,
  output logic             bclk_o,
  output logic             ws_o,
  output logic             sdata_o,
  output logic             underrun_o
);

  localparam int FW = 2 * SLOT;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = (FW > 1) ? $clog2(FW) : 1;

  // Bit i of the frame vector is frame index i, i.e. the i-th bit sent.
  function automatic logic [FW-1:0] build_frame(input logic [WIDTH-1:0] l,
                                                input logic [WIDTH-1:0] r);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f[i]        = l[WIDTH-1-i];
      f[SLOT + i] = r[WIDTH-1-i];
    end
    return f;
  endfunction

  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [WIDTH-1:0] pend_left_q, pend_left_d;
  logic [WIDTH-1:0] pend_right_q, pend_right_d;
  logic             pend_valid_q, pend_valid_d;
  logic             bclk_q, bclk_d;
  logic             ws_q, ws_d;
  logic             sdata_q, sdata_d;
  logic             underrun_q, underrun_d;

  logic             fall_tick;
  logic             accept;
  logic             load;
  logic [BW-1:0]    prev_idx;

  // Next-state logic: divider, bit counter, frame load, pending buffer.
  always_comb begin
    fall_tick    = (div_q == DW'(BCLK_DIV - 1));
    accept       = pktValid_i && !pend_valid_q;
    load         = fall_tick && (bit_q == '0);
    prev_idx     = bit_q - BW'(1);

    div_d        = fall_tick ? '0 : div_q + DW'(1);
    bclk_d       = (div_d >= DW'(BCLK_DIV / 2));

    bit_d        = bit_q;
    frame_d      = frame_q;
    ws_d         = ws_q;
    sdata_d      = sdata_q;
    underrun_d   = 1'b0;
    pend_left_d  = pend_left_q;
    pend_right_d = pend_right_q;
    pend_valid_d = pend_valid_q;

    if (fall_tick) begin
      ws_d  = (bit_q >= BW'(SLOT));
      bit_d = (bit_q == BW'(FW - 1)) ? '0 : bit_q + BW'(1);
      if (load) begin
        // Last bit of the previous frame goes out during the first slot bit.
        sdata_d = frame_q[FW-1];
        if (pend_valid_q) begin
          frame_d      = build_frame(pend_left_q, pend_right_q);
          pend_valid_d = 1'b0;
        end else begin
          frame_d    = '0;
          underrun_d = 1'b1;
        end
      end else begin
        sdata_d = frame_q[prev_idx];
      end
    end

    // Accept only happens with an empty buffer, so it never races a load.
    if (accept) begin
      pend_left_d  = leftChan_i;
      pend_right_d = rightChan_i;
      pend_valid_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge sclk_i) begin
    if (!rst_i) begin
      div_q        <= '0;
      bit_q        <= '0;
      frame_q      <= '0;
      pend_left_q  <= '0;
      pend_right_q <= '0;
      pend_valid_q <= 1'b0;
      bclk_q       <= 1'b0;
      ws_q         <= 1'b1;
      sdata_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      div_q        <= div_d;
      bit_q        <= bit_d;
      frame_q      <= frame_d;
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      pend_valid_q <= pend_valid_d;
      bclk_q       <= bclk_d;
      ws_q         <= ws_d;
      sdata_q      <= sdata_d;
      underrun_q   <= underrun_d;
    end
  end

  assign pktReady_o = !pend_valid_q;
  assign bclk_o     = bclk_q;
  assign ws_o       = ws_q;
  assign sdata_o    = sdata_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a default instance (SLOT=16) and a padded one (SLOT=24).
// Expected {underrun, ws, sdata} per bclk falling edge are queued per DUT and
// popped by a monitor at every observed bclk_o fall.
module tb_i2s_tx;

  localparam int W = 16;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [W-1:0] left, right;
  logic         valid, ready, bclk, ws, sdata, underrun;
  logic [W-1:0] p_left, p_right;
  logic         p_valid, p_ready, p_bclk, p_ws, p_sdata, p_underrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [2:0] exp_q[$];
  logic [2:0] pexp_q[$];
  logic       last_main = 1'b0;
  logic       last_pad  = 1'b0;

  i2s_tx #(.WIDTH(16), .SLOT(16), .BCLK_DIV(4)) u_dut (
    .sclk_i(clk), .rst_i(rst), .leftChan_i(left), .rightChan_i(right),
    .pktValid_i(valid), .pktReady_o(ready), .bclk_o(bclk), .ws_o(ws),
    .sdata_o(sdata), .underrun_o(underrun)
  );

  i2s_tx #(.WIDTH(16), .SLOT(24), .BCLK_DIV(4)) u_pad (
    .sclk_i(clk), .rst_i(rst), .leftChan_i(p_left), .rightChan_i(p_right),
    .pktValid_i(p_valid), .pktReady_o(p_ready), .bclk_o(p_bclk), .ws_o(p_ws),
    .sdata_o(p_sdata), .underrun_o(p_underrun)
  );

  // Counts rising edges since reset release.
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the per-fall expectations of one frame (first n_bits slots).
  task automatic push_frame(input bit pad, input logic [W-1:0] l, input logic [W-1:0] r,
                            input bit mute, input int n_bits);
    int         slot;
    logic [63:0] f;
    logic       last;
    logic [2:0] e;
    slot = pad ? 24 : 16;
    f = '0;
    if (!mute) begin
      for (int i = 0; i < W; i++) begin
        f[i]        = l[W-1-i];
        f[slot + i] = r[W-1-i];
      end
    end
    last = pad ? last_pad : last_main;
    for (int p = 0; p < n_bits; p++) begin
      if (p == 0) e = {mute, 1'b0, last};
      else        e = {1'b0, (p >= slot), f[p-1]};
      if (pad) pexp_q.push_back(e);
      else     exp_q.push_back(e);
    end
    if (n_bits == 2 * slot) begin
      if (pad) last_pad  = f[2*slot-1];
      else     last_main = f[2*slot-1];
    end
  endtask

  // Monitors: compare at every bclk fall, underrun must stay low otherwise.
  logic       prev_bclk = 1'b0;
  logic       p_prev_bclk = 1'b0;
  logic [2:0] mon_e, pmon_e;

  always @(negedge clk) begin
    if (rst) begin
      if (prev_bclk && !bclk) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("main_fall_bits", {29'd0, underrun, ws, sdata}, {29'd0, mon_e});
        end
      end else begin
        check("main_idle_underrun", underrun, 0);
      end
    end
    prev_bclk = bclk;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (p_prev_bclk && !p_bclk) begin
        if (pexp_q.size() > 0) begin
          pmon_e = pexp_q.pop_front();
          check("pad_fall_bits", {29'd0, p_underrun, p_ws, p_sdata}, {29'd0, pmon_e});
        end
      end else begin
        check("pad_idle_underrun", p_underrun, 0);
      end
    end
    p_prev_bclk = p_bclk;
  end

  // Driver tasks
  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input int exp_cyc);
    int n;
    n = 0;
    left = l; right = r; valid = 1'b1;
    while (!ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_seen", ready, 1);
    @(posedge clk); #1;
    check("accept_cycle", cyc, exp_cyc);
    check("ready_low_after_accept", ready, 0);
    valid = 1'b0;
    left = ~l; right = ~r;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bclk"}, bclk, 0);
    check({tag, "_ws"}, ws, 1);
    check({tag, "_sdata"}, sdata, 0);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_pad_ws"}, p_ws, 1);
    check({tag, "_pad_ready"}, p_ready, 1);
  endtask

  // Stimulus
  initial begin
    rst = 1'b0; valid = 1'b0; left = '0; right = '0;
    p_valid = 1'b0; p_left = '0; p_right = '0;

    push_frame(0, 16'hA5F0, 16'h0F0F, 0, 32);
    push_frame(0, 16'h1234, 16'hFEDC, 0, 32);
    push_frame(0, 16'h8001, 16'h7FFE, 0, 32);
    push_frame(0, 16'h0000, 16'h0000, 1, 32);
    push_frame(0, 16'h0000, 16'h0000, 1, 32);
    push_frame(0, 16'hFFFF, 16'hFFFF, 0, 7);
    push_frame(1, 16'hFFFF, 16'h8001, 0, 48);
    push_frame(1, 16'h0000, 16'h0000, 1, 48);

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_hold");

    left = 16'hA5F0; right = 16'h0F0F; valid = 1'b1;
    p_left = 16'hFFFF; p_right = 16'h8001; p_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("a_ready_low", ready, 0);
    check("pad_ready_low", p_ready, 0);
    check("bclk_cycle1", bclk, 0);
    p_valid = 1'b0; p_left = 16'h0000; p_right = 16'hFFFF;
    left = 16'h1234; right = 16'hFEDC;
    for (int e = 2; e <= 4; e++) begin
      @(posedge clk); #1;
      check("bclk_start", bclk, (e != 4));
      check("b_stall_ready", ready, (e == 4));
    end

    send(16'h1234, 16'hFEDC, 5);
    send(16'h8001, 16'h7FFE, 133);
    wait_cyc(520);
    send(16'hFFFF, 16'hFFFF, 521);
    wait_cyc(644);
    send(16'h5555, 16'hAAAA, 645);

    wait_cyc(671);
    rst = 1'b0;
    @(posedge clk); #1;
    check("main_q_drained", exp_q.size(), 0);
    check("pad_q_drained", pexp_q.size(), 0);
    check_reset("rst_mid");
    @(posedge clk); #1;
    last_main = 1'b0;
    push_frame(0, 16'h0000, 16'h0000, 1, 32);
    rst = 1'b1;
    wait_cyc(3);
    check("ready_after_mid_reset", ready, 1);
    wait_cyc(140);
    check("post_reset_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
